// File: rtl/lsu_mem_master.sv
// Data-side load/store initiator for a word-wide memory without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module lsu_mem_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_dmout
);

  // Handshakes: a request transfers on the edge where req_valid & req_ready;
  // a response transfers on the edge where resp_valid & resp_ready, and all
  // response outputs are held unchanged until that edge.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [2:0] LAT    = 3'(RD_LAT);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign req_ready = (state == S_IDLE);
  assign mem_wren  = (state == S_WR) & ~rst;

  assign bad = (req_size == 2'd3) |
               ((req_size == 2'd1) & req_addr[0]) |
               ((req_size == 2'd2) & (req_addr[1:0] != 2'd0));

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_dmout[7:0];
      2'd1:    byte_sel = mem_dmout[15:8];
      2'd2:    byte_sel = mem_dmout[23:16];
      default: byte_sel = mem_dmout[31:24];
    endcase
    half_sel = lane_q[1] ? mem_dmout[31:16] : mem_dmout[15:0];

    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_dmout;
    endcase

    // Overlay the store lane onto the word just read back.
    merged = mem_dmout;
    if (size_q == 2'd0) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == 2'd1) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      lane_q     <= 2'd0;
      wdata_q    <= 16'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_addr   <= 32'd0;
      mem_data   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q       <= req_wr;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            mem_addr   <= {req_addr[31:2], 2'b00};
            resp_rdata <= 32'd0;
            cnt        <= 3'd0;
            if (bad) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else if (req_wr && req_size == 2'd2) begin
              mem_data <= req_wdata;
              state    <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cnt == LAT) begin
            if (wr_q) begin
              mem_data <= merged;
              state    <= S_WR;
            end else begin
              resp_rdata <= load_ext;
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_WR: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        default: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
